// File: rtl/riscv_trace_pkg.sv
// Shared types for the riscv observation trace path: entry kinds, entry layout, field widths.
// No logic; the stored entry without timestamp is trace_body_t, with timestamp it is trace_entry_t.
// Field order matches so {trace_body_t, cycle} is bit-identical to trace_entry_t.
package riscv_trace_pkg;

    localparam int TRC_IDX_W   = 9;
    localparam int TRC_DATA_W  = 32;
    localparam int TRC_CYCLE_W = 32;

    typedef enum logic [1:0] {
        REG_WR  = 2'd0,
        MEM_WR  = 2'd1,
        MEM_RD  = 2'd2,
        MEM_ERR = 2'd3
    } trace_type_e;

    typedef struct packed {
        trace_type_e             typ;
        logic [TRC_IDX_W-1:0]    idx;
        logic [TRC_DATA_W-1:0]   data;
        logic [TRC_CYCLE_W-1:0]  cycle;
    } trace_entry_t;

    typedef struct packed {
        trace_type_e             typ;
        logic [TRC_IDX_W-1:0]    idx;
        logic [TRC_DATA_W-1:0]   data;
    } trace_body_t;

    // Memory event kind from the strobe pair; simultaneous read and write is flagged as an error.
    function automatic trace_type_e mem_type(input logic wr, input logic rd);
        if (wr && rd) begin
            return MEM_ERR;
        end
        if (wr) begin
            return MEM_WR;
        end
        return MEM_RD;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Ordered dual-push / single-pop FIFO; free_o counts empty slots including one being popped this cycle.
// Latency: a push at edge N is readable at dat_o after edge N; dat_o/vld_o depend on registers only.
// Backpressure: caller must never push more entries than free_o; pop_i is ignored when empty.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push0_i,
    input  logic [W-1:0]               dat0_i,
    input  logic                       push1_i,
    input  logic [W-1:0]               dat1_i,
    input  logic                       pop_i,
    output logic                       vld_o,
    output logic [W-1:0]               dat_o,
    output logic [$clog2(DEPTH+1)-1:0] free_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;
    logic             push_both;

    assign pop       = pop_i & (cnt_q != '0);
    // Second slot is only meaningful behind the first; a lone push always uses slot 0.
    assign push_both = push0_i & push1_i;
    assign vld_o     = (cnt_q != '0);
    assign dat_o     = mem_q[rd_ptr_q];
    assign free_o    = CNT_W'(DEPTH) - cnt_q + CNT_W'(pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push_both);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q + CNT_W'(push0_i) + CNT_W'(push_both) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push0_i) begin
            mem_q[wr_ptr_q] <= dat0_i;
        end
        if (push_both) begin
            mem_q[wr_ptr_q + PTR_W'(1)] <= dat1_i;
        end
    end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Captures riscv register-writeback and data-memory events into a FIFO, streams them out, counts drops.
// Latency: event at edge N appears on trc_* after edge N; TRACE_TIMESTAMP_EN adds the cycle stamp.
// Backpressure: trc_ready stalls the head; entries that find no free slot are dropped and counted.
module riscv_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reg_we,
    input  logic [4:0]             reg_num,
    input  logic [31:0]            reg_data,
    input  logic                   wr,
    input  logic                   rd,
    input  logic [8:0]             addr,
    input  logic [31:0]            wr_data,
    input  logic [31:0]            rd_data,
    output logic                   trc_valid,
    input  logic                   trc_ready,
    output logic [1:0]             trc_type,
    output logic [TRC_IDX_W-1:0]   trc_idx,
    output logic [TRC_DATA_W-1:0]  trc_data,
    output logic [TRC_CYCLE_W-1:0] trc_cycle,
    output logic                   ovf,
    input  logic                   clr_ovf,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH+1);
`ifdef TRACE_TIMESTAMP_EN
    localparam int STORE_W = $bits(trace_entry_t);
`else
    localparam int STORE_W = $bits(trace_body_t);
`endif

    trace_body_t        reg_body, mem_body, body0;
    trace_entry_t       head_ent;
    logic [STORE_W-1:0] dat0, dat1, head_dat;
    logic [CNT_W-1:0]   fifo_free;
    logic               fifo_vld;
    logic               pop;
    logic               mem_ev;
    logic               push_reg, push_mem;
    logic [1:0]         drops;

    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d, drop_base;
    logic [DROP_W:0]    drop_sum;
    logic               ovf_q, ovf_d;

    assign mem_ev = wr | rd;
    assign pop    = fifo_vld & trc_ready;

    always_comb begin
        reg_body      = '0;
        reg_body.typ  = REG_WR;
        reg_body.idx  = {4'b0, reg_num};
        reg_body.data = reg_data;

        mem_body      = '0;
        mem_body.typ  = mem_type(wr, rd);
        mem_body.idx  = addr;
        mem_body.data = rd & ~wr ? rd_data : wr_data;
    end

    // Slot allocation: the register entry is ordered first, so with one free slot the memory entry loses.
    always_comb begin
        push_reg = reg_we & (fifo_free != '0);
        push_mem = mem_ev & (reg_we ? (fifo_free >= CNT_W'(2)) : (fifo_free != '0));
        body0    = push_reg ? reg_body : mem_body;
        drops    = {1'b0, reg_we & ~push_reg} + {1'b0, mem_ev & ~push_mem};
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [TRC_CYCLE_W-1:0] cycle_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + TRC_CYCLE_W'(1);
        end
    end

    assign dat0     = {body0, cycle_q};
    assign dat1     = {mem_body, cycle_q};
    assign head_ent = head_dat;
`else
    assign dat0     = body0;
    assign dat1     = mem_body;
    assign head_ent = {head_dat, {TRC_CYCLE_W{1'b0}}};
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (STORE_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push0_i (push_reg | push_mem),
        .dat0_i  (dat0),
        .push1_i (push_reg & push_mem),
        .dat1_i  (dat1),
        .pop_i   (pop),
        .vld_o   (fifo_vld),
        .dat_o   (head_dat),
        .free_o  (fifo_free)
    );

    // A clear in the same cycle as a drop wipes the old history but still records this cycle's losses.
    always_comb begin
        drop_base  = clr_ovf ? '0 : drop_cnt_q;
        drop_sum   = {1'b0, drop_base} + (DROP_W+1)'(drops);
        drop_cnt_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        ovf_d      = (ovf_q & ~clr_ovf) | (drops != 2'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Head RAM is not reset, so fields are masked to zero while the FIFO is empty.
    assign trc_valid = fifo_vld;
    assign trc_type  = fifo_vld ? head_ent.typ   : 2'b00;
    assign trc_idx   = fifo_vld ? head_ent.idx   : '0;
    assign trc_data  = fifo_vld ? head_ent.data  : '0;
    assign trc_cycle = fifo_vld ? head_ent.cycle : '0;
    assign ovf       = ovf_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Directed bench for riscv_trace_buffer; expected timestamps follow TRACE_TIMESTAMP_EN (zero when undefined).
module tb_riscv_trace_buffer;
    import riscv_trace_pkg::*;

    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_we = 1'b0;
    logic [4:0]  reg_num = '0;
    logic [31:0] reg_data = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [8:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data = '0;
    logic        trc_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        trc_valid;
    logic [1:0]  trc_type;
    logic [8:0]  trc_idx;
    logic [31:0] trc_data;
    logic [31:0] trc_cycle;
    logic        ovf;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] tb_cyc;

    riscv_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .reg_we(reg_we), .reg_num(reg_num), .reg_data(reg_data),
        .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_type(trc_type), .trc_idx(trc_idx),
        .trc_data(trc_data), .trc_cycle(trc_cycle), .ovf(ovf), .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle count: edges seen since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    function automatic logic [31:0] exp_ts(input logic [31:0] c);
`ifdef TRACE_TIMESTAMP_EN
        return c;
`else
        return 32'h0;
`endif
    endfunction

    task automatic idle();
        reg_we = 1'b0; wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", trc_valid); end
        checks++; if (trc_type !== 2'd0) begin errors++; $display("FAIL rst_type got %0d want 0", trc_type); end
        checks++; if (trc_idx !== 9'd0) begin errors++; $display("FAIL rst_idx got %0h want 0", trc_idx); end
        checks++; if (trc_data !== 32'd0) begin errors++; $display("FAIL rst_data got %0h want 0", trc_data); end
        checks++; if (trc_cycle !== 32'd0) begin errors++; $display("FAIL rst_cycle got %0h want 0", trc_cycle); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b want 0", ovf); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single_reg();
        @(negedge clk);
        reset = 1'b1; trc_ready = 1'b1;
        reg_we = 1'b1; reg_num = 5'd5; reg_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL t1_comb_valid got %0b want 0", trc_valid); end
        step(); idle();
        checks++; if (trc_valid !== 1'b1 || trc_type !== REG_WR || trc_idx !== 9'd5)
            begin errors++; $display("FAIL t1_head got v=%0b t=%0d i=%0d want v=1 t=0 i=5", trc_valid, trc_type, trc_idx); end
        checks++; if (trc_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_data got %0h want deadbeef", trc_data); end
        checks++; if (trc_cycle !== exp_ts(32'd0)) begin errors++; $display("FAIL t1_cycle got %0d want %0d", trc_cycle, exp_ts(32'd0)); end
        step();
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL t1_popped got %0b want 0", trc_valid); end
        trc_ready = 1'b0;
    endtask

    task automatic test_dual_push();
        logic [31:0] c;
        c = tb_cyc;
        reg_we = 1'b1; reg_num = 5'd3; reg_data = 32'd7;
        wr = 1'b1; addr = 9'd12; wr_data = 32'd99;
        step(); idle();
        checks++; if (trc_valid !== 1'b1 || trc_type !== REG_WR || trc_idx !== 9'd3 || trc_data !== 32'd7 || trc_cycle !== exp_ts(c))
            begin errors++; $display("FAIL t2_first got v=%0b t=%0d i=%0d d=%0d c=%0d want 1/0/3/7/%0d", trc_valid, trc_type, trc_idx, trc_data, trc_cycle, exp_ts(c)); end
        step();
        checks++; if (trc_type !== REG_WR || trc_idx !== 9'd3)
            begin errors++; $display("FAIL t2_stall got t=%0d i=%0d want 0/3", trc_type, trc_idx); end
        trc_ready = 1'b1;
        step();
        checks++; if (trc_valid !== 1'b1 || trc_type !== MEM_WR || trc_idx !== 9'd12 || trc_data !== 32'd99 || trc_cycle !== exp_ts(c))
            begin errors++; $display("FAIL t2_second got v=%0b t=%0d i=%0d d=%0d c=%0d want 1/1/12/99/%0d", trc_valid, trc_type, trc_idx, trc_data, trc_cycle, exp_ts(c)); end
        step();
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL t2_empty got %0b want 0", trc_valid); end
        trc_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] c0;
        c0 = tb_cyc;
        for (int i = 0; i < 20; i++) begin
            reg_we = 1'b1; reg_num = 5'(i); reg_data = 32'h1000 + 32'(i);
            step();
        end
        idle();
        checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL t3_drop got %0d want 4", drop_cnt); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL t3_ovf got %0b want 1", ovf); end
        trc_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (trc_valid !== 1'b1 || trc_idx !== 9'(i) || trc_data !== 32'h1000 + 32'(i) || trc_cycle !== exp_ts(c0 + 32'(i)))
                begin errors++; $display("FAIL t3_entry%0d got v=%0b i=%0d d=%0h c=%0d want 1/%0d/%0h/%0d", i, trc_valid, trc_idx, trc_data, trc_cycle, i, 32'h1000 + 32'(i), exp_ts(c0 + 32'(i))); end
            step();
        end
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL t3_empty got %0b want 0", trc_valid); end
        trc_ready = 1'b0;
    endtask

    task automatic test_full_with_pop();
        int n;
        for (int i = 0; i < 15; i++) begin
            reg_we = 1'b1; reg_num = 5'(i); reg_data = 32'(i);
            step();
        end
        trc_ready = 1'b1;
        reg_we = 1'b1; reg_num = 5'd9; reg_data = 32'hAAAA;
        wr = 1'b1; addr = 9'd21; wr_data = 32'hBBBB;
        step(); idle();
        trc_ready = 1'b0;
        checks++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL t4_drop got %0d want 4", drop_cnt); end
        step();
        trc_ready = 1'b1;
        n = 0;
        while (trc_valid === 1'b1 && n < 40) begin
            if (n == 14) begin
                checks++; if (trc_type !== REG_WR || trc_idx !== 9'd9)
                    begin errors++; $display("FAIL t4_reg got t=%0d i=%0d want 0/9", trc_type, trc_idx); end
            end
            if (n == 15) begin
                checks++; if (trc_type !== MEM_WR || trc_idx !== 9'd21 || trc_data !== 32'hBBBB)
                    begin errors++; $display("FAIL t4_mem got t=%0d i=%0d d=%0h want 1/21/bbbb", trc_type, trc_idx, trc_data); end
            end
            n++;
            step();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL t4_count got %0d want 16", n); end
        trc_ready = 1'b0;
    endtask

    task automatic test_mem_err();
        logic [31:0] c;
        c = tb_cyc;
        wr = 1'b1; rd = 1'b1; addr = 9'd3; wr_data = 32'd55; rd_data = 32'd66;
        step(); idle();
        checks++; if (trc_valid !== 1'b1 || trc_type !== MEM_ERR || trc_idx !== 9'd3 || trc_data !== 32'd55 || trc_cycle !== exp_ts(c))
            begin errors++; $display("FAIL t5_err got v=%0b t=%0d i=%0d d=%0d c=%0d want 1/3/3/55/%0d", trc_valid, trc_type, trc_idx, trc_data, trc_cycle, exp_ts(c)); end
        trc_ready = 1'b1;
        step();
        rd = 1'b1; addr = 9'h1FF; rd_data = 32'h77;
        step(); idle();
        checks++; if (trc_valid !== 1'b1 || trc_type !== MEM_RD || trc_idx !== 9'h1FF || trc_data !== 32'h77)
            begin errors++; $display("FAIL t5_rd got v=%0b t=%0d i=%0h d=%0h want 1/2/1ff/77", trc_valid, trc_type, trc_idx, trc_data); end
        step();
        trc_ready = 1'b0;
    endtask

    task automatic test_clr_ovf();
        int n;
        for (int i = 0; i < 15; i++) begin
            reg_we = 1'b1; reg_num = 5'(i); reg_data = 32'(i);
            step();
        end
        reg_we = 1'b1; reg_num = 5'd30; reg_data = 32'h1E;
        wr = 1'b1; addr = 9'd7; wr_data = 32'h70;
        step();
        checks++; if (drop_cnt !== 16'd5 || ovf !== 1'b1)
            begin errors++; $display("FAIL t5_free1 got drop=%0d ovf=%0b want 5/1", drop_cnt, ovf); end
        clr_ovf = 1'b1;
        step(); idle();
        checks++; if (drop_cnt !== 16'd2 || ovf !== 1'b1)
            begin errors++; $display("FAIL t5_clr_drop got drop=%0d ovf=%0b want 2/1", drop_cnt, ovf); end
        clr_ovf = 1'b1;
        step(); idle();
        checks++; if (drop_cnt !== 16'd0 || ovf !== 1'b0)
            begin errors++; $display("FAIL t5_clr got drop=%0d ovf=%0b want 0/0", drop_cnt, ovf); end
        trc_ready = 1'b1;
        n = 0;
        while (trc_valid === 1'b1 && n < 40) begin
            if (n == 15) begin
                checks++; if (trc_type !== REG_WR || trc_idx !== 9'd30)
                    begin errors++; $display("FAIL t5_last got t=%0d i=%0d want 0/30", trc_type, trc_idx); end
            end
            n++;
            step();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL t5_count got %0d want 16", n); end
        trc_ready = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 0; i < 8; i++) begin
            reg_we = 1'b1; reg_num = 5'(i); reg_data = 32'(i);
            step();
        end
        idle();
        wr = 1'b1; addr = 9'd4; wr_data = 32'd4;
        step(); idle();
        trc_ready = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (trc_valid !== 1'b0 || trc_data !== 32'd0)
            begin errors++; $display("FAIL t6_async got v=%0b d=%0h want 0/0", trc_valid, trc_data); end
        checks++; if (drop_cnt !== 16'd0 || ovf !== 1'b0)
            begin errors++; $display("FAIL t6_cnt got drop=%0d ovf=%0b want 0/0", drop_cnt, ovf); end
        step();
        step();
        reset = 1'b1;
        reg_we = 1'b1; reg_num = 5'd1; reg_data = 32'd11;
        #1;
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL t6_empty got %0b want 0", trc_valid); end
        step(); idle();
        checks++; if (trc_valid !== 1'b1 || trc_idx !== 9'd1 || trc_data !== 32'd11 || trc_cycle !== exp_ts(32'd0))
            begin errors++; $display("FAIL t6_restart got v=%0b i=%0d d=%0d c=%0d want 1/1/11/%0d", trc_valid, trc_idx, trc_data, trc_cycle, exp_ts(32'd0)); end
        step();
        checks++; if (trc_valid !== 1'b0) begin errors++; $display("FAIL t6_stale got %0b want 0", trc_valid); end
        trc_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_dual_push();
        test_overflow();
        test_full_with_pop();
        test_mem_err();
        test_clr_ovf();
        test_reset_mid_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
